dmem_access_unit: RTL and testbench

Memory-stage data-memory controller between the execute→memory pipeline register and the memory→writeback pipeline register. Takes the memory-stage address, store data and control, and runs a valid/ready request and response handshake to a variable-latency data memory. While an access is in flight it stalls the pipeline. It delivers the load result as `m_dmem_rd` for capture into the writeback bus.

---
 rtl/dmem_access_unit_pkg.sv | 43 ++++
 rtl/dmem_access_unit.sv | 140 ++++++++++++++
 tb/tb_dmem_access_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared memory-stage definitions: access FSM states, memory bus request/response
// fields and the result-select encoding that m_is_load is decoded from.
package dmem_access_unit_pkg;

  localparam int XLEN                 = 32;
  localparam int DMEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    DMEM_IDLE     = 2'd0,
    DMEM_REQ      = 2'd1,
    DMEM_WAIT_RSP = 2'd2,
    DMEM_DONE     = 2'd3
  } dmem_state_t;

  // Writeback result source; RES_MEM marks a load.
  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_IMM = 2'd3
  } result_sel_t;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rdata;
  } mem_rsp_t;

  function automatic logic is_load_sel(input result_sel_t sel);
    return sel == RES_MEM;
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_access_unit.sv
// Memory-stage data-memory controller: issues one valid/ready request per load or
// store, stalls the pipeline while it is in flight, and registers the load result.
//
// state    | meaning
// IDLE     | no access in flight; detect a new access
// REQ      | mem_req_valid high, waiting for mem_req_ready
// WAIT_RSP | load accepted, waiting for mem_rsp_valid or timeout
// DONE     | one un-stalled cycle so the pipeline advances
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m_valid,
  input  logic        m_is_load,
  input  logic        m_dmem_we,
  input  logic [31:0] m_alu_out,
  input  logic [31:0] m_dmem_wd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic [31:0] m_dmem_rd,
  output logic        stall,
  output logic        err_misaligned,
  output logic        err_timeout
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  dmem_state_t state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic        err_mis_q, err_mis_d;
  logic        err_to_q, err_to_d;

  logic access;
  logic aligned;

  assign access  = m_valid & (m_is_load | m_dmem_we);
  assign aligned = (m_alu_out[1:0] == 2'b00);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    err_mis_d = 1'b0;
    err_to_d  = 1'b0;

    case (state_q)
      DMEM_IDLE: begin
        if (access) begin
          if (aligned) begin
            // A store wins when both load and store are flagged.
            req_d.valid = 1'b1;
            req_d.we    = m_dmem_we;
            req_d.addr  = word_align(m_alu_out);
            req_d.wdata = m_dmem_wd;
            state_d     = DMEM_REQ;
          end else begin
            err_mis_d = 1'b1;
            if (!m_dmem_we) begin
              rd_d = ERR_RDATA;
            end
            state_d = DMEM_DONE;
          end
        end
      end

      DMEM_REQ: begin
        if (mem_req_ready) begin
          req_d.valid = 1'b0;
          cnt_d       = 8'd0;
          state_d     = req_q.we ? DMEM_DONE : DMEM_WAIT_RSP;
        end
      end

      DMEM_WAIT_RSP: begin
        cnt_d = cnt_q + 8'd1;
        // A response in the final counted cycle still wins over the abort.
        if (mem_rsp_valid) begin
          rd_d    = mem_rsp_rdata;
          state_d = DMEM_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rd_d     = ERR_RDATA;
          err_to_d = 1'b1;
          state_d  = DMEM_DONE;
        end
      end

      DMEM_DONE: begin
        state_d = DMEM_IDLE;
      end

      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= DMEM_IDLE;
      req_q     <= '0;
      cnt_q     <= 8'd0;
      rd_q      <= 32'h0000_0000;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      err_mis_q <= err_mis_d;
      err_to_q  <= err_to_d;
    end
  end

  // Stall rises in the detect cycle itself so the access instruction stays put.
  assign stall = ((state_q == DMEM_IDLE) & access & aligned)
               | (state_q == DMEM_REQ)
               | (state_q == DMEM_WAIT_RSP);

  assign mem_req_valid  = req_q.valid;
  assign mem_req_we     = req_q.we;
  assign mem_req_addr   = req_q.addr;
  assign mem_req_wdata  = req_q.wdata;
  assign m_dmem_rd      = rd_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit; load results go through an expected-value queue.
module tb_dmem_access_unit;

  localparam int          TB_TIMEOUT = 8;
  localparam logic [31:0] TB_ERR     = 32'hBAD0_0BAD;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m_valid, m_is_load, m_dmem_we;
  logic [31:0] m_alu_out, m_dmem_wd;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic [31:0] m_dmem_rd;
  logic        stall, err_misaligned, err_timeout;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_access_unit #(
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .ERR_RDATA     (TB_ERR)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .m_valid       (m_valid),
    .m_is_load     (m_is_load),
    .m_dmem_we     (m_dmem_we),
    .m_alu_out     (m_alu_out),
    .m_dmem_wd     (m_dmem_wd),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .m_dmem_rd     (m_dmem_rd),
    .stall         (stall),
    .err_misaligned(err_misaligned),
    .err_timeout   (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, m_dmem_rd);
    end else begin
      chk(tag, m_dmem_rd, exp_q.pop_front());
    end
  endtask

  task automatic acc(input logic v, input logic ld, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd);
    m_valid   = v;
    m_is_load = ld;
    m_dmem_we = we;
    m_alu_out = addr;
    m_dmem_wd = wd;
  endtask

  initial begin
    rstn          = 1'b0;
    acc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd", m_dmem_rd, 32'h0);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_errs", {30'b0, err_misaligned, err_timeout}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Load 0x10, ready in REQ, response next cycle
    @(negedge clk);
    acc(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h77);
    mem_req_ready = 1'b1;
    exp_q.push_back(32'hCAFE_F00D);
    #1;
    chk("ld_c0_stall", {31'b0, stall}, 32'h1);
    chk("ld_c0_valid", {31'b0, mem_req_valid}, 32'h0);
    @(negedge clk);
    #1;
    chk("ld_c1_valid", {31'b0, mem_req_valid}, 32'h1);
    chk("ld_c1_addr", mem_req_addr, 32'h0000_0010);
    chk("ld_c1_we", {31'b0, mem_req_we}, 32'h0);
    chk("ld_c1_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hCAFE_F00D;
    #1;
    chk("ld_c2_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("ld_c2_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    acc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("ld_c3_stall", {31'b0, stall}, 32'h0);
    sb_check("ld_c3_rd");
    @(negedge clk);
    #1;
    chk("ld_c4_rd_hold", m_dmem_rd, 32'hCAFE_F00D);

    // Store 0x20 with ready low for 4 REQ cycles
    @(negedge clk);
    acc(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    #1;
    chk("st_c0_stall", {31'b0, stall}, 32'h1);
    chk("st_c0_valid", {31'b0, mem_req_valid}, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      mem_req_ready = (i == 5);
      #1;
      chk($sformatf("st_c%0d_valid", i), {31'b0, mem_req_valid}, 32'h1);
      chk($sformatf("st_c%0d_addr", i), mem_req_addr, 32'h0000_0020);
      chk($sformatf("st_c%0d_wdata", i), mem_req_wdata, 32'h1234_5678);
      chk($sformatf("st_c%0d_we", i), {31'b0, mem_req_we}, 32'h1);
      chk($sformatf("st_c%0d_stall", i), {31'b0, stall}, 32'h1);
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    acc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("st_done_stall", {31'b0, stall}, 32'h0);
    chk("st_done_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("st_rd_unchanged", m_dmem_rd, 32'hCAFE_F00D);
    @(negedge clk);

    // Misaligned load 0x13
    @(negedge clk);
    acc(1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0);
    exp_q.push_back(TB_ERR);
    #1;
    chk("mis_c0_stall", {31'b0, stall}, 32'h0);
    chk("mis_c0_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("mis_c0_err", {31'b0, err_misaligned}, 32'h0);
    @(negedge clk);
    acc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("mis_c1_err", {31'b0, err_misaligned}, 32'h1);
    chk("mis_c1_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("mis_c1_stall", {31'b0, stall}, 32'h0);
    sb_check("mis_c1_rd");
    @(negedge clk);
    #1;
    chk("mis_c2_err", {31'b0, err_misaligned}, 32'h0);

    // Back-to-back load then store; stray response during REQ
    @(negedge clk);
    acc(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    exp_q.push_back(32'h5A5A_A5A5);
    #1;
    chk("bb_c0_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h1111_1111;
    #1;
    chk("bb_c1_valid", {31'b0, mem_req_valid}, 32'h1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    chk("bb_c2_stray_ignored", m_dmem_rd, TB_ERR);
    chk("bb_c2_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h5A5A_A5A5;
    #1;
    chk("bb_c3_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    acc(1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0000_BBBB);
    #1;
    chk("bb_c4_done_stall", {31'b0, stall}, 32'h0);
    chk("bb_c4_done_valid", {31'b0, mem_req_valid}, 32'h0);
    sb_check("bb_c4_rd");
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    chk("bb_c5_detect_stall", {31'b0, stall}, 32'h1);
    chk("bb_c5_valid", {31'b0, mem_req_valid}, 32'h0);
    @(negedge clk);
    #1;
    chk("bb_c6_valid", {31'b0, mem_req_valid}, 32'h1);
    chk("bb_c6_addr", mem_req_addr, 32'h0000_0044);
    chk("bb_c6_we", {31'b0, mem_req_we}, 32'h1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    acc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("bb_c7_stall", {31'b0, stall}, 32'h0);
    chk("bb_c7_rd_hold", m_dmem_rd, 32'h5A5A_A5A5);

    // Load with no response: timeout after 8 WAIT_RSP cycles
    @(negedge clk);
    acc(1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    mem_req_ready = 1'b1;
    exp_q.push_back(TB_ERR);
    @(negedge clk);
    #1;
    chk("to_c1_valid", {31'b0, mem_req_valid}, 32'h1);
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      #1;
      chk($sformatf("to_c%0d_stall", i), {31'b0, stall}, 32'h1);
      chk($sformatf("to_c%0d_err", i), {31'b0, err_timeout}, 32'h0);
    end
    @(negedge clk);
    acc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("to_c10_err", {31'b0, err_timeout}, 32'h1);
    chk("to_c10_stall", {31'b0, stall}, 32'h0);
    sb_check("to_c10_rd");
    @(negedge clk);
    #1;
    chk("to_c11_err", {31'b0, err_timeout}, 32'h0);

    // Reset while in WAIT_RSP, late response after release
    @(negedge clk);
    acc(1'b1, 1'b1, 1'b0, 32'h0000_0090, 32'h0000_7777);
    mem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk("rr_wait_stall", {31'b0, stall}, 32'h1);
    rstn = 1'b0;
    acc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rr_rd", m_dmem_rd, 32'h0);
    chk("rr_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("rr_addr", mem_req_addr, 32'h0);
    chk("rr_wdata", mem_req_wdata, 32'h0);
    chk("rr_stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("rr_late_rd", m_dmem_rd, 32'h0);
    chk("rr_late_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("rr_late_stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    #1;
    chk("rr_idle_rd", m_dmem_rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
